song_reader: RTL and testbench

- Feeds the note arranger one 16-bit song word at a time.
- Reads words from a synchronous song ROM and presents each with a one-cycle new_note pulse.
- Waits for the arranger's note_done one-pulse before fetching the next word.
- Sits between the top-level play/song controls and the arranger's note_to_load/load_new_note/note_done handshake.

---
 rtl/song_reader_pkg.sv | 28 ++
 rtl/song_reader_if.sv | 21 ++
 rtl/dffr.sv | 15 +
 rtl/song_reader_song_rom.sv | 14 +
 rtl/song_reader.sv | 96 +++++++++
 tb/tb_song_reader.sv | 370 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/song_reader_pkg.sv
// Shared definitions for the song reader: song-word field layout and FSM states.
package song_reader_pkg;

    localparam int ADV_BIT   = 15;
    localparam int NOTE_MSB  = 14;
    localparam int NOTE_LSB  = 9;
    localparam int DUR_MSB   = 8;
    localparam int DUR_LSB   = 2;
    localparam int BEATS_MSB = 8;
    localparam int BEATS_LSB = 3;

    localparam logic [15:0] END_MARKER = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        PRESENT,
        WAIT_DONE,
        ADVANCE,
        END
    } state_t;

    function automatic logic is_end(input logic [15:0] word);
        return word == END_MARKER;
    endfunction

endpackage

// File: rtl/song_reader_if.sv
// Play/song controls in, arranger note handshake out.
interface song_reader_if #(
    parameter int SONG_BITS = 2
);
    logic                 play;
    logic [SONG_BITS-1:0] song;
    logic                 note_done;
    logic [15:0]          note;
    logic                 new_note;
    logic                 song_done;

    modport master (
        output play, song, note_done,
        input  note, new_note, song_done
    );

    modport slave (
        input  play, song, note_done,
        output note, new_note, song_done
    );
endinterface

// File: rtl/dffr.sv
// Generic register with synchronous active-low reset to INIT.
module dffr #(
    parameter int         W    = 1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!reset) q <= INIT;
        else        q <= d;
    end
endmodule

// File: rtl/song_reader_song_rom.sv
// Song ROM, one 16-bit word per {song, addr}; contents fixed by INIT.
module song_rom #(
    parameter int SONG_BITS = 2,
    parameter int ADDR_BITS = 5,
    parameter logic [(16 << (SONG_BITS + ADDR_BITS)) - 1:0] INIT = '0
) (
    input  logic                           clk,
    input  logic [SONG_BITS+ADDR_BITS-1:0] addr,
    output logic [15:0]                    dout
);
    always_ff @(posedge clk) begin
        dout <= INIT[int'(addr) * 16 +: 16];
    end
endmodule

// File: rtl/song_reader.sv
// Walks a song ROM word by word, handing each word to the arranger
// and waiting for note_done before fetching the next.
module song_reader #(
    parameter int SONG_BITS = 2,
    parameter int ADDR_BITS = 5,
    parameter logic [(16 << (SONG_BITS + ADDR_BITS)) - 1:0] ROM_INIT = '0
) (
    input logic          clk,
    input logic          reset,
    song_reader_if.slave bus
);
    import song_reader_pkg::*;

    logic [2:0]           state_q;
    state_t               state, state_n;
    logic [ADDR_BITS-1:0] addr, addr_n;
    logic [SONG_BITS-1:0] cur_song, song_n;
    logic [15:0]          note, note_n, rom_data;
    logic                 song_chg;

    assign state = state_t'(state_q);

    dffr #(.W(3), .INIT(3'(IDLE))) u_state (
        .clk(clk), .reset(reset), .d(3'(state_n)), .q(state_q)
    );
    dffr #(.W(ADDR_BITS)) u_addr (
        .clk(clk), .reset(reset), .d(addr_n), .q(addr)
    );
    dffr #(.W(SONG_BITS)) u_song (
        .clk(clk), .reset(reset), .d(song_n), .q(cur_song)
    );
    dffr #(.W(16)) u_note (
        .clk(clk), .reset(reset), .d(note_n), .q(note)
    );

    song_rom #(
        .SONG_BITS(SONG_BITS),
        .ADDR_BITS(ADDR_BITS),
        .INIT     (ROM_INIT)
    ) u_rom (
        .clk (clk),
        .addr({cur_song, addr}),
        .dout(rom_data)
    );

    // A new song selection restarts the fetch from word 0 from any busy state.
    assign song_chg = (state != IDLE) && (bus.song != cur_song);

    always_comb begin
        state_n = state;
        addr_n  = addr;
        song_n  = cur_song;
        note_n  = note;
        if (song_chg) begin
            state_n = FETCH;
            addr_n  = '0;
            song_n  = bus.song;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.play) begin
                        state_n = FETCH;
                        addr_n  = '0;
                        song_n  = bus.song;
                    end
                end
                FETCH:    state_n = WAIT_ROM;
                WAIT_ROM: begin
                    if (is_end(rom_data)) begin
                        state_n = END;
                    end else begin
                        note_n  = rom_data;
                        state_n = PRESENT;
                    end
                end
                PRESENT:   state_n = bus.note_done ? ADVANCE : WAIT_DONE;
                WAIT_DONE: if (bus.note_done) state_n = ADVANCE;
                ADVANCE: begin
                    if (&addr) begin
                        state_n = END;
                    end else if (bus.play) begin
                        addr_n  = addr + 1'b1;
                        state_n = FETCH;
                    end
                end
                END:     state_n = END;
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.note      = note;
    assign bus.new_note  = (state == PRESENT);
    assign bus.song_done = (state == END);

endmodule

// File: tb/tb_song_reader.sv
// Randomized self-checking bench for song_reader against a word-list model.
module tb_song_reader;
    import song_reader_pkg::*;

    localparam int SB = 2;
    localparam int AB = 5;
    localparam int NW = 32;

    function automatic logic [15:0] rom_word(input int s, input int a);
        logic [15:0] w;
        w = 16'(((s * 7 + a) * 2741 + 913) & 32'h7ffc) | 16'h0204;
        if (a % 5 == 4) w = 16'h8000 | 16'(((a + s + 1) & 63) << BEATS_LSB);
        case (s)
            0: w = (a == 0) ? 16'h1A40 : (a == 1) ? 16'h8050 : END_MARKER;
            2: if (a >= 6) w = END_MARKER;
            3: if (a >= 13) w = END_MARKER;
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic [2047:0] build_rom();
        logic [2047:0] r;
        r = '0;
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < NW; a++)
                r[(s * NW + a) * 16 +: 16] = rom_word(s, a);
        return r;
    endfunction

    localparam logic [2047:0] ROM_INIT = build_rom();

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;

    song_reader_if #(.SONG_BITS(SB)) bus ();

    song_reader #(
        .SONG_BITS(SB),
        .ADDR_BITS(AB),
        .ROM_INIT (ROM_INIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until new_note is seen; n = cycles taken, or limit+1 if none.
    // k >= 0 holds play low for cycles 1..k and high afterwards.
    task automatic wait_pulse(input int limit, input int k, output int n);
        n = limit + 1;
        for (int j = 1; j <= limit; j++) begin
            tick();
            bus.note_done = 1'b0;
            if (k >= 0) bus.play = (j > k);
            if (bus.new_note) begin
                n = j;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.play = 1'b0;
        bus.note_done = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.song = '0;
        do_reset();
        n_checks += 3;
        if (bus.note !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_note: got %h want 0000", bus.note);
        end
        if (bus.new_note !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_new_note: got %b want 0", bus.new_note);
        end
        if (bus.song_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_song_done: got %b want 0", bus.song_done);
        end
    endtask

    task automatic test_first_word();
        int n;
        bus.song = 2'd0;
        bus.play = 1'b1;
        wait_pulse(8, -1, n);
        n_checks += 3;
        if (n !== 3) begin
            n_fail++;
            $display("FAIL first_latency: got %0d want 3", n);
        end
        if (bus.note !== 16'h1A40) begin
            n_fail++;
            $display("FAIL first_note: got %h want 1a40", bus.note);
        end
        if (bus.song_done !== 1'b0) begin
            n_fail++;
            $display("FAIL first_song_done: got %b want 0", bus.song_done);
        end
    endtask

    task automatic test_hold();
        int n;
        int bad;
        bad = 0;
        bus.note_done = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (bus.new_note || bus.note !== 16'h1A40) bad++;
        end
        n_checks += 1;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hold_stable: got %0d bad cycles want 0", bad);
        end
        bus.note_done = 1'b1;
        wait_pulse(8, -1, n);
        n_checks += 3;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL done_latency: got %0d want 4", n);
        end
        if (bus.note !== 16'h8050) begin
            n_fail++;
            $display("FAIL second_note: got %h want 8050", bus.note);
        end
        if (bus.note[BEATS_MSB:BEATS_LSB] !== 6'd10) begin
            n_fail++;
            $display("FAIL beats: got %0d want 10", bus.note[BEATS_MSB:BEATS_LSB]);
        end
    endtask

    task automatic test_end_marker();
        int pulses;
        int low_done;
        pulses = 0;
        low_done = 0;
        bus.note_done = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            tick();
            bus.note_done = 1'($urandom_range(0, 1));
            bus.play = 1'($urandom_range(0, 1));
            if (bus.new_note) pulses++;
            if (j > 5 && !bus.song_done) low_done++;
        end
        n_checks += 3;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL end_pulses: got %0d want 0", pulses);
        end
        if (low_done !== 0) begin
            n_fail++;
            $display("FAIL end_song_done: got %0d low cycles want 0", low_done);
        end
        if (bus.note !== 16'h8050) begin
            n_fail++;
            $display("FAIL end_note: got %h want 8050", bus.note);
        end
    endtask

    task automatic test_advance_hold();
        int n;
        int pulses;
        pulses = 0;
        do_reset();
        bus.song = 2'd1;
        bus.play = 1'b1;
        wait_pulse(8, -1, n);
        bus.note_done = 1'b1;
        tick();
        bus.note_done = 1'b0;
        bus.play = 1'b0;
        for (int j = 0; j < 50; j++) begin
            tick();
            if (bus.new_note) pulses++;
        end
        n_checks += 1;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL adv_hold: got %0d pulses want 0", pulses);
        end
        bus.play = 1'b1;
        wait_pulse(8, -1, n);
        n_checks += 2;
        if (n !== 3) begin
            n_fail++;
            $display("FAIL adv_resume: got %0d want 3", n);
        end
        if (bus.note !== rom_word(1, 1)) begin
            n_fail++;
            $display("FAIL adv_note: got %h want %h", bus.note, rom_word(1, 1));
        end
    endtask

    task automatic test_song_change();
        int n;
        tick();
        bus.song = 2'd2;
        tick();
        bus.note_done = 1'b1;
        n_checks += 1;
        if (bus.new_note !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_fetch: got %b want 0", bus.new_note);
        end
        wait_pulse(8, -1, n);
        n_checks += 2;
        if (n !== 2) begin
            n_fail++;
            $display("FAIL chg_latency: got %0d want 2 after fetch", n);
        end
        if (bus.note !== rom_word(2, 0)) begin
            n_fail++;
            $display("FAIL chg_note: got %h want %h", bus.note, rom_word(2, 0));
        end
        bus.note_done = 1'b1;
        wait_pulse(8, -1, n);
        n_checks += 2;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL chg_next_latency: got %0d want 4", n);
        end
        if (bus.note !== rom_word(2, 1)) begin
            n_fail++;
            $display("FAIL chg_next_note: got %h want %h", bus.note, rom_word(2, 1));
        end
    endtask

    // Plays song s start to finish with random note_done delays and
    // random play gaps; the model is the song's word list up to END_MARKER.
    task automatic run_song(input int s);
        logic [15:0] words[$];
        int n, d, k, pulses, extra;
        words.delete();
        for (int a = 0; a < NW; a++) begin
            if (rom_word(s, a) == END_MARKER) break;
            words.push_back(rom_word(s, a));
        end
        pulses = 0;
        extra = 0;
        do_reset();
        bus.song = 2'(s);
        bus.play = 1'b1;
        wait_pulse(8, -1, n);
        if (n == 3) pulses++;
        for (int i = 0; i < words.size(); i++) begin
            n_checks += 1;
            if (bus.note !== words[i]) begin
                n_fail++;
                $display("FAIL song%0d_word%0d: got %h want %h", s, i, bus.note, words[i]);
            end
            d = $urandom_range(0, 3);
            k = $urandom_range(0, 2);
            for (int j = 0; j < d; j++) begin
                bus.note_done = 1'b0;
                bus.play = 1'($urandom_range(0, 1));
                tick();
                if (bus.new_note || bus.note !== words[i]) extra++;
            end
            bus.note_done = 1'b1;
            if (i < words.size() - 1) begin
                wait_pulse(12, k, n);
                n_checks += 1;
                if (n !== 4 + k) begin
                    n_fail++;
                    $display("FAIL song%0d_lat%0d: got %0d want %0d", s, i, n, 4 + k);
                end else begin
                    pulses++;
                end
            end else begin
                wait_pulse(8, k, n);
                n_checks += 2;
                if (n !== 9) begin
                    n_fail++;
                    $display("FAIL song%0d_tail_pulse: got pulse at %0d want none", s, n);
                end
                if (bus.song_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL song%0d_done: got %b want 1", s, bus.song_done);
                end
            end
        end
        n_checks += 2;
        if (pulses !== words.size()) begin
            n_fail++;
            $display("FAIL song%0d_pulses: got %0d want %0d", s, pulses, words.size());
        end
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL song%0d_extra: got %0d bad cycles want 0", s, extra);
        end
    endtask

    task automatic test_full_song();
        run_song(1);
    endtask

    task automatic test_mid_reset();
        int n;
        do_reset();
        bus.song = 2'd3;
        bus.play = 1'b1;
        wait_pulse(8, -1, n);
        bus.note_done = 1'b1;
        wait_pulse(12, -1, n);
        tick();
        reset = 1'b0;
        tick();
        n_checks += 3;
        if (bus.note !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset_note: got %h want 0000", bus.note);
        end
        if (bus.song_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_done: got %b want 0", bus.song_done);
        end
        if (bus.new_note !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_pulse: got %b want 0", bus.new_note);
        end
        reset = 1'b1;
        tick();
        n_checks += 1;
        if (bus.new_note !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_pulse: got %b want 0", bus.new_note);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) run_song($urandom_range(0, 3));
    endtask

    initial begin
        reset = 1'b0;
        bus.play = 1'b0;
        bus.song = '0;
        bus.note_done = 1'b0;
        test_reset();
        test_first_word();
        test_hold();
        test_end_marker();
        test_advance_hold();
        test_song_change();
        test_full_song();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
